// File: rtl/vending_ctrl.sv
// Vending controller: handshaked price/quantity load, coin credit with overflow
// rejection, refund-over-select-over-coin priority, and a terminal EMPTY state.
module vend_slot #(
    parameter int PRICE_W = 8,
    parameter int QTY_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld_price,
    input  logic               ld_qty,
    input  logic               dec,
    input  logic [PRICE_W-1:0] din,
    output logic [PRICE_W-1:0] price,
    output logic [QTY_W-1:0]   qty
);
    always_ff @(posedge clk) begin
        if (rst) begin
            price <= '0;
            qty   <= '0;
        end else begin
            if (ld_price) price <= din;
            if (ld_qty) qty <= din[QTY_W-1:0];
            else if (dec && qty != '0) qty <= qty - 1'b1;
        end
    end
endmodule

module vending_ctrl #(
    parameter int PRODUCT_NUM = 4,
    parameter int PRICE_W     = 8,
    parameter int QTY_W       = 4,
    parameter int SEL_W       = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PRICE_W-1:0] DI,
    input  logic               di_valid,
    input  logic [PRICE_W-1:0] MI,
    input  logic [SEL_W-1:0]   sel,
    input  logic               re,
    output logic [PRICE_W:0]   MO,
    output logic [SEL_W-1:0]   PO,
    output logic [1:0]         err,
    output logic               coin_rej,
    output logic [PRICE_W-1:0] credit,
    output logic               empty
);
    localparam int CW = (2 * PRODUCT_NUM > 2) ? $clog2(2 * PRODUCT_NUM) : 1;
    localparam logic [CW-1:0] LAST_WORD = CW'(2 * PRODUCT_NUM - 1);

    typedef enum logic [1:0] {LOAD, RUN, EMPTY} state_t;

    state_t state, state_nxt;
    logic [CW-1:0] wcnt, wcnt_nxt;
    logic [PRICE_W-1:0] credit_nxt;
    logic [PRICE_W:0] mo_nxt;
    logic [SEL_W-1:0] po_nxt;
    logic [1:0] err_nxt;
    logic rej_nxt;

    logic [PRODUCT_NUM-1:0][PRICE_W-1:0] prices;
    logic [PRODUCT_NUM-1:0][QTY_W-1:0]   qtys;
    logic [PRODUCT_NUM-1:0] ld_price, ld_qty, dec;

    logic [PRICE_W:0]   sum;
    logic [PRICE_W-1:0] sel_price;
    logic [QTY_W-1:0]   sel_qty;
    logic sel_ok, sale, any_left;

    assign sum    = {1'b0, credit} + {1'b0, MI};
    assign sel_ok = (sel != '0) && (sel <= SEL_W'(PRODUCT_NUM));
    assign sale   = (state == RUN) && !re && sel_ok && (sel_qty != '0) &&
                    (sum >= {1'b0, sel_price});

    for (genvar i = 0; i < PRODUCT_NUM; i++) begin : g_slot
        assign ld_price[i] = (state == LOAD) && di_valid && (wcnt == CW'(2 * i));
        assign ld_qty[i]   = (state == LOAD) && di_valid && (wcnt == CW'(2 * i + 1));
        assign dec[i]      = sale && (sel == SEL_W'(i + 1));
        vend_slot #(.PRICE_W(PRICE_W), .QTY_W(QTY_W)) u_slot (
            .clk(clk), .rst(rst), .ld_price(ld_price[i]), .ld_qty(ld_qty[i]),
            .dec(dec[i]), .din(DI), .price(prices[i]), .qty(qtys[i])
        );
    end

    always_comb begin
        sel_price = '0;
        sel_qty   = '0;
        for (int i = 0; i < PRODUCT_NUM; i++) begin
            if (sel == SEL_W'(i + 1)) begin
                sel_price = prices[i];
                sel_qty   = qtys[i];
            end
        end
    end

    // Stock that will remain after this edge, including the word being loaded
    always_comb begin
        any_left = 1'b0;
        for (int i = 0; i < PRODUCT_NUM; i++) begin
            if (ld_qty[i])   any_left = any_left | (DI[QTY_W-1:0] != '0);
            else if (dec[i]) any_left = any_left | (qtys[i] > QTY_W'(1));
            else             any_left = any_left | (qtys[i] != '0);
        end
    end

    always_comb begin
        state_nxt  = state;
        wcnt_nxt   = wcnt;
        credit_nxt = credit;
        mo_nxt     = '0;
        po_nxt     = '0;
        err_nxt    = 2'd0;
        rej_nxt    = 1'b0;
        case (state)
            LOAD: begin
                if (di_valid) begin
                    if (wcnt == LAST_WORD) state_nxt = any_left ? RUN : EMPTY;
                    else wcnt_nxt = wcnt + 1'b1;
                end
            end
            RUN: begin
                if (re) begin
                    mo_nxt     = sum;
                    credit_nxt = '0;
                end else if (sale) begin
                    po_nxt     = sel;
                    mo_nxt     = sum - {1'b0, sel_price};
                    credit_nxt = '0;
                    if (!any_left) state_nxt = EMPTY;
                end else begin
                    if (sel_ok && sel_qty == '0) err_nxt = 2'd2;
                    else if (sel_ok)             err_nxt = 2'd1;
                    else if (sel != '0)          err_nxt = 2'd3;
                    if (!sum[PRICE_W]) begin
                        credit_nxt = sum[PRICE_W-1:0];
                    end else begin
                        mo_nxt  = {1'b0, MI};
                        rej_nxt = 1'b1;
                    end
                end
            end
            EMPTY: begin
                if (MI != '0) begin
                    mo_nxt  = {1'b0, MI};
                    rej_nxt = 1'b1;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LOAD;
            wcnt     <= '0;
            credit   <= '0;
            MO       <= '0;
            PO       <= '0;
            err      <= 2'd0;
            coin_rej <= 1'b0;
            empty    <= 1'b0;
        end else begin
            state    <= state_nxt;
            wcnt     <= wcnt_nxt;
            credit   <= credit_nxt;
            MO       <= mo_nxt;
            PO       <= po_nxt;
            err      <= err_nxt;
            coin_rej <= rej_nxt;
            empty    <= (state_nxt == EMPTY);
        end
    end
endmodule

// File: tb/tb_vending_ctrl.sv
module tb_vending_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] DI;
    logic       di_valid;
    logic [7:0] MI;
    logic [2:0] sel;
    logic       re;
    logic [8:0] MO;
    logic [2:0] PO;
    logic [1:0] err;
    logic       coin_rej;
    logic [7:0] credit;
    logic       empty;

    vending_ctrl #(.PRODUCT_NUM(4), .PRICE_W(8), .QTY_W(4), .SEL_W(3)) dut (
        .clk(clk), .rst(rst), .DI(DI), .di_valid(di_valid), .MI(MI), .sel(sel),
        .re(re), .MO(MO), .PO(PO), .err(err), .coin_rej(coin_rej),
        .credit(credit), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       r;
        bit [7:0] di;
        bit       dv;
        bit [7:0] mi;
        bit [2:0] s;
        bit       rf;
        bit [8:0] mo;
        bit [2:0] po;
        bit [1:0] e;
        bit       rej;
        bit [7:0] cr;
        bit       em;
        bit       emdc;
    } vec_t;

    vec_t tbl[$];
    int checks = 0;
    int errors = 0;

    task automatic push(bit r, bit [7:0] di, bit dv, bit [7:0] mi, bit [2:0] s, bit rf,
                        bit [8:0] mo, bit [2:0] po, bit [1:0] e, bit rej, bit [7:0] cr,
                        bit em, bit emdc);
        vec_t v;
        v.r = r; v.di = di; v.dv = dv; v.mi = mi; v.s = s; v.rf = rf;
        v.mo = mo; v.po = po; v.e = e; v.rej = rej; v.cr = cr; v.em = em; v.emdc = emdc;
        tbl.push_back(v);
    endtask

    task automatic rst_v();
        push(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic ld(bit [7:0] w, bit emdc = 0);
        push(0, w, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, emdc);
    endtask
    task automatic idle(bit em);
        push(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, em, 0);
    endtask
    task automatic run(bit [7:0] mi, bit [2:0] s, bit rf, bit [8:0] mo, bit [2:0] po,
                       bit [1:0] e, bit rej, bit [7:0] cr, bit em = 0, bit emdc = 0);
        push(0, 0, 0, mi, s, rf, mo, po, e, rej, cr, em, emdc);
    endtask

    initial begin
        bit [7:0] words1[8];
        bit [7:0] words2[8];
        int n;
        words1 = '{50, 1, 30, 0, 20, 2, 10, 15};
        words2 = '{0, 1, 100, 0, 7, 0, 9, 1};

        rst = 1'b1; DI = '0; di_valid = 1'b0; MI = '0; sel = '0; re = 1'b0;

        rst_v();
        foreach (words1[i]) begin
            ld(words1[i]);
            idle(0);
        end
        run(20, 0, 0, 0, 0, 0, 0, 20);
        run(20, 2, 0, 0, 0, 2, 0, 40);
        run(20, 1, 0, 10, 1, 0, 0, 0);
        run(5, 3, 0, 0, 0, 1, 0, 5);
        run(10, 3, 1, 15, 0, 0, 0, 0);
        run(250, 0, 0, 0, 0, 0, 0, 250);
        run(10, 0, 0, 10, 0, 0, 1, 250);
        run(0, 4, 0, 240, 4, 0, 0, 0);
        run(0, 5, 0, 0, 0, 3, 0, 0);
        run(50, 1, 0, 0, 0, 2, 0, 50);
        run(0, 0, 1, 50, 0, 0, 0, 0);
        run(200, 0, 0, 0, 0, 0, 0, 200);
        run(55, 7, 0, 0, 0, 3, 0, 255);
        run(1, 0, 0, 1, 0, 0, 1, 255);
        run(0, 0, 1, 255, 0, 0, 0, 0);
        run(20, 3, 0, 0, 3, 0, 0, 0);
        run(20, 3, 0, 0, 3, 0, 0, 0);
        run(20, 3, 0, 0, 0, 2, 0, 20);
        run(0, 3, 1, 20, 0, 0, 0, 0);
        for (int k = 0; k < 14; k++) run(15, 4, 0, 5, 4, 0, 0, 0, 0, k == 13);
        idle(1);
        run(20, 4, 0, 20, 0, 0, 1, 0, 1);
        run(7, 0, 0, 7, 0, 0, 1, 0, 1);
        run(0, 2, 1, 0, 0, 0, 0, 0, 1);
        rst_v();
        ld(11); ld(22); ld(33);
        rst_v();
        foreach (words2[i]) ld(words2[i]);
        run(9, 4, 0, 0, 4, 0, 0, 0);
        run(100, 2, 0, 0, 0, 2, 0, 100);
        run(0, 0, 1, 100, 0, 0, 0, 0);
        run(0, 1, 0, 0, 1, 0, 0, 0, 0, 1);
        idle(1);
        rst_v();
        for (int i = 0; i < 8; i++) ld(0, i == 7);
        idle(1);
        run(9, 1, 1, 9, 0, 0, 1, 0, 1);

        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].r; DI = tbl[i].di; di_valid = tbl[i].dv;
            MI = tbl[i].mi; sel = tbl[i].s; re = tbl[i].rf;
            @(posedge clk);
            #1;
            checks++;
            if (MO !== tbl[i].mo || PO !== tbl[i].po || err !== tbl[i].e ||
                coin_rej !== tbl[i].rej || credit !== tbl[i].cr ||
                (!tbl[i].emdc && empty !== tbl[i].em)) begin
                errors++;
                $display("FAIL vec%0d: got MO=%0d PO=%0d err=%0d rej=%0b credit=%0d empty=%0b, need MO=%0d PO=%0d err=%0d rej=%0b credit=%0d empty=%0b%s",
                         i, MO, PO, err, coin_rej, credit, empty, tbl[i].mo, tbl[i].po,
                         tbl[i].e, tbl[i].rej, tbl[i].cr, tbl[i].em,
                         tbl[i].emdc ? "(dc)" : "");
            end
        end

        @(negedge clk);
        rst = 1'b1; DI = '0; di_valid = 1'b0; MI = '0; sel = '0; re = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (MO !== '0 || PO !== '0 || err !== '0 || coin_rej !== 1'b0 ||
            credit !== '0 || empty !== 1'b0) begin
            errors++;
            $display("FAIL reset state: MO=%0d PO=%0d err=%0d rej=%0b credit=%0d empty=%0b",
                     MO, PO, err, coin_rej, credit, empty);
        end

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            DI = '0; di_valid = 1'b1;
            @(negedge clk);
        end
        di_valid = 1'b0;
        n = 0;
        while (empty !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL timeout: empty not asserted within %0d cycles after zero-stock load", n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
